// File: rtl/idc_pkg.sv
// Shared constants, FSM state encodings and the sample-to-brightness conversion
// for the image display controller output stage.
package idc_pkg;

  localparam int PIX_W  = 8;
  localparam int IN_W   = 7;
  localparam int BLK    = 4;
  localparam int OFFSET = 64;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_FILL = 2'd1;
  localparam logic [1:0] W_DROP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_SEND = 1'b1;

  // Bias wraps -64..63 onto 0..127; the shift makes brightness always even.
  function automatic logic [PIX_W-1:0] to_pix(input logic [IN_W-1:0] d);
    logic [IN_W-1:0] biased;
    biased = d + IN_W'(OFFSET);
    return {biased, 1'b0};
  endfunction

endpackage

// File: rtl/idc_disp_out_if.sv
// Controller-side burst input and display-side pixel stream of the output stage.
interface idc_disp_out_if;
  import idc_pkg::*;

  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic             pix_sof;
  logic             pix_eol;
  logic             pix_eof;
  logic             frame_drop;
  logic             frame_err;

  modport master (
    output in_valid, in_data, pix_ready,
    input  pix_valid, pix_data, pix_sof, pix_eol, pix_eof, frame_drop, frame_err
  );

  modport slave (
    input  in_valid, in_data, pix_ready,
    output pix_valid, pix_data, pix_sof, pix_eol, pix_eof, frame_drop, frame_err
  );
endinterface

// File: rtl/idc_pingpong_ram.sv
// Two 16-entry frame banks with per-bank full flags and a read port whose
// output register only updates when a new pixel is loaded.
module idc_pingpong_ram
  import idc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [3:0]       wr_idx,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             set_full,
  input  logic             clr_full,
  input  logic             clr_bank,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [3:0]       rd_idx,
  output logic [PIX_W-1:0] rd_data,
  output logic [1:0]       full
);

  logic [PIX_W-1:0] mem [2][16];

  // NOTE: storage is deliberately left out of reset; the full flags alone decide
  // whether a bank holds a valid frame, and this keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_idx] <= wr_data;
  end

  // NOTE: non-blocking assignments let the set and the clear of different banks
  // on one edge both land, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= '0;
      rd_data <= '0;
    end else begin
      if (clr_full) full[clr_bank] <= 1'b0;
      if (set_full) full[wr_bank]  <= 1'b1;
      if (rd_en)    rd_data        <= mem[rd_bank][rd_idx];
    end
  end

endmodule

// File: rtl/idc_disp_out.sv
// Output stage: captures 4x4 bursts into ping-pong banks and streams them,
// optionally 2x upscaled, over a valid/ready pixel interface.
module idc_disp_out
  import idc_pkg::*;
#(
  parameter int SCALE = 2
) (
  input logic           clk,
  input logic           rst,
  idc_disp_out_if.slave bus
);

  localparam logic [2:0] LAST = 3'(BLK * SCALE - 1);

  logic [1:0]       w_state;
  logic [3:0]       wcnt;
  logic             wr_bank;
  logic             fill_ok, wr_en, set_full;
  logic [3:0]       wr_idx;
  logic [1:0]       full;
  logic             drop_q, err_q;

  logic [0:0]       r_state, r_next;
  logic             rd_bank, ld_bank, load, rel_bank, pix_valid;
  logic [2:0]       row, col, ld_row, ld_col;
  logic [1:0]       src_row, src_col;
  logic             sof_q, eol_q, eof_q;
  logic [PIX_W-1:0] rd_data;

  // Write side judges bank availability on the registered flags, so a release
  // on the same edge as a burst start does not help that burst.
  assign fill_ok  = (w_state == W_FILL) || (w_state == W_IDLE && !full[wr_bank]);
  assign wr_en    = bus.in_valid && fill_ok;
  assign wr_idx   = (w_state == W_FILL) ? wcnt : 4'd0;
  assign set_full = bus.in_valid && (w_state == W_FILL) && (wcnt == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      wcnt    <= '0;
      wr_bank <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      err_q  <= 1'b0;
      case (w_state)
        W_IDLE: if (bus.in_valid) begin
          if (full[wr_bank]) w_state <= W_DROP;
          else begin
            w_state <= W_FILL;
            wcnt    <= 4'd1;
          end
        end
        W_FILL: if (!bus.in_valid) begin
          err_q   <= 1'b1;
          w_state <= W_IDLE;
        end else if (wcnt == 4'd15) begin
          wr_bank <= ~wr_bank;
          w_state <= W_IDLE;
        end else begin
          wcnt <= wcnt + 4'd1;
        end
        W_DROP: if (!bus.in_valid) begin
          drop_q  <= 1'b1;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign pix_valid = (r_state == R_SEND);

  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    r_next   = r_state;
    load     = 1'b0;
    rel_bank = 1'b0;
    ld_bank  = rd_bank;
    ld_row   = row;
    ld_col   = col;
    case (r_state)
      R_IDLE: if (full[rd_bank]) begin
        load   = 1'b1;
        r_next = R_SEND;
        ld_row = '0;
        ld_col = '0;
      end
      R_SEND: if (bus.pix_ready) begin
        if (row == LAST && col == LAST) begin
          rel_bank = 1'b1;
          ld_bank  = ~rd_bank;
          ld_row   = '0;
          ld_col   = '0;
          if (full[~rd_bank]) load = 1'b1;
          else r_next = R_IDLE;
        end else if (col == LAST) begin
          load   = 1'b1;
          ld_row = row + 3'd1;
          ld_col = '0;
        end else begin
          load   = 1'b1;
          ld_col = col + 3'd1;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Nearest-neighbour upscale: each source pixel covers a SCALE x SCALE block.
  assign src_row = (SCALE == 2) ? ld_row[2:1] : ld_row[1:0];
  assign src_col = (SCALE == 2) ? ld_col[2:1] : ld_col[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      rd_bank <= 1'b0;
      row     <= '0;
      col     <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      r_state <= r_next;
      if (rel_bank) rd_bank <= ~rd_bank;
      if (load) begin
        row   <= ld_row;
        col   <= ld_col;
        sof_q <= (ld_row == 3'd0) && (ld_col == 3'd0);
        eol_q <= (ld_col == LAST);
        eof_q <= (ld_row == LAST) && (ld_col == LAST);
      end else if (r_next == R_IDLE) begin
        sof_q <= 1'b0;
        eol_q <= 1'b0;
        eof_q <= 1'b0;
      end
    end
  end

  idc_pingpong_ram u_ram (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_bank  (wr_bank),
    .wr_idx   (wr_idx),
    .wr_data  (to_pix(bus.in_data)),
    .set_full (set_full),
    .clr_full (rel_bank),
    .clr_bank (rd_bank),
    .rd_en    (load),
    .rd_bank  (ld_bank),
    .rd_idx   ({src_row, src_col}),
    .rd_data  (rd_data),
    .full     (full)
  );

  assign bus.pix_valid  = pix_valid;
  assign bus.pix_data   = rd_data;
  assign bus.pix_sof    = sof_q;
  assign bus.pix_eol    = eol_q;
  assign bus.pix_eof    = eof_q;
  assign bus.frame_drop = drop_q;
  assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_idc_disp_out.sv
// Scoreboard bench: SCALE=1 and SCALE=2 instances; stimulus pushes expected
// pixels into queues, per-instance monitors pop and compare on each handshake.
module tb_idc_disp_out;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  idc_disp_out_if bus1();
  idc_disp_out_if bus2();

  idc_disp_out #(.SCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  idc_disp_out #(.SCALE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int   checks = 0;
  int   errors = 0;
  pix_t q1[$];
  pix_t q2[$];
  int   stim[64];
  int   hs2    = 0;
  int   drop2  = 0;
  int   err2   = 0;

  localparam int T2[16] = '{-64, -1, 0, 63, 1, -2, 2, -3, 10, -10, 20, -20, 30, -30, 62, -63};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int sel, input logic v, input int d);
    if (sel == 1) begin
      bus1.in_valid = v;
      bus1.in_data  = 7'(d);
    end else begin
      bus2.in_valid = v;
      bus2.in_data  = 7'(d);
    end
  endtask

  // Sample i is captured on the edge after it is driven; one idle cycle follows.
  task automatic drive(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      set_in(sel, 1'b1, stim[i]);
    end
    @(posedge clk); #1;
    set_in(sel, 1'b0, 0);
  endtask

  task automatic push_frame(input int sel, input int off);
    int   sc;
    int   side;
    pix_t e;
    sc   = (sel == 1) ? 1 : 2;
    side = 4 * sc;
    for (int r = 0; r < side; r++) begin
      for (int c = 0; c < side; c++) begin
        e.data = 8'((stim[off + (r / sc) * 4 + c / sc] + 64) * 2);
        e.sof  = (r == 0) && (c == 0);
        e.eol  = (c == side - 1);
        e.eof  = (r == side - 1) && (c == side - 1);
        if (sel == 1) q1.push_back(e);
        else q2.push_back(e);
      end
    end
  endtask

  task automatic wait_drain(input int sel, input int budget, input string name);
    int n;
    n = 0;
    while (((sel == 1) ? q1.size() : q2.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, (sel == 1) ? q1.size() : q2.size(), 0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_dut1"}, {bus1.pix_valid, bus1.pix_data, bus1.pix_sof, bus1.pix_eol,
                            bus1.pix_eof, bus1.frame_drop, bus1.frame_err}, 0);
    check({name, "_dut2"}, {bus2.pix_valid, bus2.pix_data, bus2.pix_sof, bus2.pix_eol,
                            bus2.pix_eof, bus2.frame_drop, bus2.frame_err}, 0);
  endtask

  initial begin : mon1
    pix_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus1.pix_valid && bus1.pix_ready) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pix1 unexpected: got data %0d with no pixel expected", bus1.pix_data);
        end else begin
          e = q1.pop_front();
          check("pix1", {bus1.pix_data, bus1.pix_sof, bus1.pix_eol, bus1.pix_eof}, e);
        end
      end
    end
  end

  initial begin : mon2
    pix_t        e;
    logic        hold_v;
    logic [11:0] hold;
    hold_v = 1'b0;
    hold   = '0;
    forever begin
      @(negedge clk);
      if (rst) hold_v = 1'b0;
      else begin
        if (bus2.frame_drop) drop2++;
        if (bus2.frame_err)  err2++;
        if (hold_v)
          check("stall_hold", {bus2.pix_valid, bus2.pix_data, bus2.pix_sof,
                               bus2.pix_eol, bus2.pix_eof}, hold);
        hold_v = bus2.pix_valid && !bus2.pix_ready;
        hold   = {bus2.pix_valid, bus2.pix_data, bus2.pix_sof, bus2.pix_eol, bus2.pix_eof};
        if (bus2.pix_valid && bus2.pix_ready) begin
          if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pix2 unexpected: got data %0d with no pixel expected", bus2.pix_data);
          end else begin
            e = q2.pop_front();
            check("pix2", {bus2.pix_data, bus2.pix_sof, bus2.pix_eol, bus2.pix_eof}, e);
          end
          hs2++;
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int gaps;
    int target;
    int n;
    set_in(1, 1'b0, 0);
    set_in(2, 1'b0, 0);
    bus1.pix_ready = 1'b1;
    bus2.pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst = 1'b0;

    // SCALE=1 ramp: -64..-49 -> 0,2..30, then latency of the first pix_valid.
    for (int i = 0; i < 16; i++) stim[i] = i - 64;
    push_frame(1, 0);
    drive(1, 16);
    @(negedge clk);
    check("latency_edge_e", bus1.pix_valid, 1'b0);
    @(negedge clk);
    check("latency_edge_e1", bus1.pix_valid, 1'b1);
    check("first_pix_sof", {bus1.pix_data, bus1.pix_sof}, {8'd0, 1'b1});
    wait_drain(1, 200, "drain_scale1");

    // SCALE=2 upscale with boundary values -64, 0 and 63.
    for (int i = 0; i < 16; i++) stim[i] = T2[i];
    push_frame(2, 0);
    drive(2, 16);
    wait_drain(2, 300, "drain_scale2");

    // Same frame with ready toggling every cycle.
    push_frame(2, 0);
    fork
      drive(2, 16);
      begin
        repeat (180) begin
          @(posedge clk); #1;
          bus2.pix_ready = ~bus2.pix_ready;
        end
      end
    join
    bus2.pix_ready = 1'b1;
    wait_drain(2, 300, "drain_toggle");

    // Three back-to-back bursts under back-pressure: two stored, third dropped.
    for (int i = 0; i < 16; i++) begin
      stim[i]      = i * 4 - 32;
      stim[16 + i] = 50 - i * 5;
      stim[32 + i] = 7;
    end
    push_frame(2, 0);
    push_frame(2, 16);
    @(posedge clk); #1;
    bus2.pix_ready = 1'b0;
    drive(2, 48);
    repeat (3) @(posedge clk);
    #1;
    check("drop_pulse_count", drop2, 1);
    check("stalled_valid", bus2.pix_valid, 1'b1);
    check("stalled_queue", q2.size(), 128);
    @(posedge clk); #1;
    bus2.pix_ready = 1'b1;
    gaps = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (!bus2.pix_valid) gaps++;
    end
    check("no_gap_between_frames", gaps, 0);
    wait_drain(2, 50, "drain_two_frames");
    @(negedge clk);
    check("idle_after_frames", bus2.pix_valid, 1'b0);

    // Short burst of 9 then a full burst: one frame_err, only the full one shown.
    for (int i = 0; i < 16; i++) stim[i] = 20 - i * 3;
    push_frame(2, 0);
    drive(2, 9);
    drive(2, 16);
    wait_drain(2, 300, "drain_after_short");
    check("err_pulse_count", err2, 1);
    check("drop_count_unchanged", drop2, 1);

    // Reset part-way through a frame, then a clean frame.
    for (int i = 0; i < 16; i++) stim[i] = 63 - i * 8;
    push_frame(2, 0);
    target = hs2 + 20;
    drive(2, 16);
    n = 0;
    while (hs2 < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reached_pixel_20", hs2, target);
    check("dut1_idle_queue", q1.size(), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("reset_mid_stream");
    q2.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    check("no_pixel_after_reset", bus2.pix_valid, 1'b0);
    for (int i = 0; i < 16; i++) stim[i] = i * 7 - 50;
    push_frame(2, 0);
    drive(2, 16);
    wait_drain(2, 300, "drain_after_reset");

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
